// File: rtl/ssd_scan_capture.sv
// ssd_scan_capture: receive side of an 8-digit multiplexed seven-segment bus.
// Synchronizes the anode/cathode lines, waits for each scanned digit to hold
// still for STABLE_CYCLES, decodes the glyph back to hex and stores it in an
// 8-entry digit file with per-digit valid bits, readable through rd_sel.
module ssd_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       anode_0,
    input  logic       anode_1,
    input  logic       anode_2,
    input  logic       anode_3,
    input  logic       anode_4,
    input  logic       anode_5,
    input  logic       anode_6,
    input  logic       anode_7,
    input  logic       cathode_A,
    input  logic       cathode_B,
    input  logic       cathode_C,
    input  logic       cathode_D,
    input  logic       cathode_E,
    input  logic       cathode_F,
    input  logic       cathode_G,
    input  logic       clear,
    input  logic [2:0] rd_sel,
    output logic [3:0] rd_num,
    output logic       rd_valid,
    output logic [7:0] valid_mask,
    output logic       frame_done,
    output logic       seg_err,
    output logic       anode_err
);

    localparam int PW = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Decode an A..G cathode pattern (active-low) to {legal, hex value}.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [PW-1:0] raw_pat;
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] pat;
    logic [PW-1:0] pat_prev;
    logic [7:0]    anode_act;
    logic [6:0]    cath;
    logic          any_act;
    logic          change;

    assign raw_pat = {anode_7, anode_6, anode_5, anode_4,
                      anode_3, anode_2, anode_1, anode_0,
                      cathode_A, cathode_B, cathode_C, cathode_D,
                      cathode_E, cathode_F, cathode_G};

    // Input synchronizer chain; flops idle at 1, the inactive level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
        end else begin
            sync_q[0] <= raw_pat;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign pat       = sync_q[SYNC_STAGES-1];
    assign anode_act = ~pat[14:7];
    assign cath      = pat[6:0];
    assign any_act   = |anode_act;
    assign change    = (pat != pat_prev);

    // Previous synchronized pattern, used to detect any change of P.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pat_prev <= '1;
        else        pat_prev <= pat;
    end

    logic [3:0] act_cnt;
    logic [2:0] act_idx;

    // Count active anodes and locate the (last) active one.
    always_comb begin
        act_cnt = '0;
        act_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (anode_act[i]) begin
                act_cnt = act_cnt + 4'd1;
                act_idx = 3'(i);
            end
        end
    end

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] cnt_inc;
    logic       at_window;

    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign at_window = (cnt_inc == 9'(STABLE_CYCLES));

    // FSM state and settle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: the counter tracks how many cycles P has held so far.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_act) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            SETTLE: begin
                if (change) begin
                    if (any_act) cnt_d = 8'd1;
                    else         state_d = IDLE;
                end else if (at_window) begin
                    state_d = HOLD;
                    cnt_d   = cnt_inc[7:0];
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            HOLD: begin
                if (change) begin
                    if (any_act) begin
                        state_d = SETTLE;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    logic       eval;
    logic [4:0] dec;
    logic       do_write;
    logic       do_blank;
    logic       do_seg_err;
    logic       do_anode_err;

    // Output decode: the last SETTLE cycle of a full window evaluates P.
    always_comb begin
        eval         = (state_q == SETTLE) && !change && at_window;
        dec          = glyph_decode(cath);
        do_write     = eval && (act_cnt == 4'd1) && dec[4];
        do_blank     = eval && (act_cnt == 4'd1) && (cath == 7'h7F);
        do_seg_err   = eval && (act_cnt == 4'd1) && !dec[4] && (cath != 7'h7F);
        do_anode_err = eval && (act_cnt > 4'd1);
    end

    logic [7:0] valid_d;

    // Next valid mask; clear overrides any set in the same cycle.
    always_comb begin
        valid_d = valid_mask;
        if (do_write) valid_d[act_idx] = 1'b1;
        if (do_blank) valid_d[act_idx] = 1'b0;
        if (clear)    valid_d = '0;
    end

    logic [3:0] digit_q [8];

    // Valid bits, frame pulse and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_mask <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            anode_err  <= 1'b0;
        end else begin
            valid_mask <= valid_d;
            frame_done <= (valid_d == 8'hFF) && (valid_mask != 8'hFF);
            seg_err    <= clear ? 1'b0 : (seg_err | do_seg_err);
            anode_err  <= clear ? 1'b0 : (anode_err | do_anode_err);
        end
    end

    // Digit register file; written on a legal glyph even when clear is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
        end else if (do_write) begin
            digit_q[act_idx] <= dec[3:0];
        end
    end

    // Registered readback of the selected digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_num   <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_num   <= digit_q[rd_sel];
            rd_valid <= valid_mask[rd_sel];
        end
    end

endmodule
